// File: rtl/mips_pkg.sv
// Shared constants and types for the 8-bit teaching MIPS core.
package mips_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned PC_W   = 6;
    localparam int unsigned REG_N  = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned OP_W   = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_e;

    typedef struct packed {
        logic    reg_dst;
        logic    alu_src;
        logic    mem_to_reg;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    branch;
        logic    jump;
        alu_op_e alu_op;
    } ctrl_t;

endpackage

// File: rtl/reg_file.sv
// 32x8 register file: two async read ports, one sync write port, async clear.
module reg_file
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [REG_AW-1:0] raddr1_i,
    input  logic [REG_AW-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o
);

    logic [DATA_W-1:0] regs_q [REG_N];

    // Register 0 is never written, so it stays at its cleared value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(REG_N); i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/id_stage.sv
// Instruction decode: register file, control decode, immediate and next-PC resolution.
module id_stage
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              Zero,
    input  logic [DATA_W-1:0] WriteBack,
    input  logic [31:0]       Instruction,
    input  logic [PC_W-1:0]   PCnext,
    output logic [DATA_W-1:0] readd1,
    output logic [DATA_W-1:0] readd2,
    output logic              ALUSrc,
    output logic              MemtoReg,
    output logic              MemWrite,
    output logic              MemRead,
    output logic              RegWrite,
    output logic [1:0]        ALUop,
    output logic [PC_W-1:0]   PCJout,
    output logic [DATA_W-1:0] SignExtendOut
);

    logic [OP_W-1:0]   opcode;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] wr_addr;
    logic [PC_W-1:0]   pc_branch;
    ctrl_t             ctrl_c;
    logic              unused_instr_bits;

    assign opcode            = Instruction[31:26];
    assign rs                = Instruction[25:21];
    assign rt                = Instruction[20:16];
    assign rd                = Instruction[15:11];
    assign unused_instr_bits = ^Instruction[10:8];

    always_comb begin
        ctrl_c = '0;
        case (opcode)
            OP_RTYPE: begin
                ctrl_c.reg_dst   = 1'b1;
                ctrl_c.reg_write = 1'b1;
                ctrl_c.alu_op    = ALU_FUNCT;
            end
            OP_LW: begin
                ctrl_c.alu_src    = 1'b1;
                ctrl_c.mem_to_reg = 1'b1;
                ctrl_c.mem_read   = 1'b1;
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.alu_op     = ALU_ADD;
            end
            OP_SW: begin
                ctrl_c.alu_src   = 1'b1;
                ctrl_c.mem_write = 1'b1;
                ctrl_c.alu_op    = ALU_ADD;
            end
            OP_ADDI: begin
                ctrl_c.alu_src   = 1'b1;
                ctrl_c.reg_write = 1'b1;
                ctrl_c.alu_op    = ALU_ADD;
            end
            OP_BEQ: begin
                ctrl_c.branch = 1'b1;
                ctrl_c.alu_op = ALU_SUB;
            end
            OP_J: begin
                ctrl_c.jump = 1'b1;
            end
            default: ;
        endcase
    end

    assign ALUSrc        = ctrl_c.alu_src;
    assign MemtoReg      = ctrl_c.mem_to_reg;
    assign MemWrite      = ctrl_c.mem_write;
    assign MemRead       = ctrl_c.mem_read;
    assign RegWrite      = ctrl_c.reg_write;
    assign ALUop         = ctrl_c.alu_op;
    assign SignExtendOut = Instruction[DATA_W-1:0];

    assign wr_addr = ctrl_c.reg_dst ? rd : rt;

    // Branch target wraps modulo the 6-bit word-addressed PC space.
    assign pc_branch = PC_W'(PCnext + SignExtendOut[PC_W-1:0]);

    always_comb begin
        PCJout = PCnext;
        if (ctrl_c.jump) begin
            PCJout = Instruction[PC_W-1:0];
        end else if (ctrl_c.branch && Zero) begin
            PCJout = pc_branch;
        end
    end

    reg_file u_reg_file (
        .clk      (clk),
        .rst_n    (rst),
        .we_i     (ctrl_c.reg_write),
        .waddr_i  (wr_addr),
        .wdata_i  (WriteBack),
        .raddr1_i (rs),
        .raddr2_i (rt),
        .rdata1_o (readd1),
        .rdata2_o (readd2)
    );

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: stimulus queues expectations, a negedge monitor checks them.
module tb_id_stage;

    logic        clk;
    logic        rst;
    logic        Zero;
    logic [7:0]  WriteBack;
    logic [31:0] Instruction;
    logic [5:0]  PCnext;
    logic [7:0]  readd1;
    logic [7:0]  readd2;
    logic        ALUSrc;
    logic        MemtoReg;
    logic        MemWrite;
    logic        MemRead;
    logic        RegWrite;
    logic [1:0]  ALUop;
    logic [5:0]  PCJout;
    logic [7:0]  SignExtendOut;

    id_stage dut (
        .clk           (clk),
        .rst           (rst),
        .Zero          (Zero),
        .WriteBack     (WriteBack),
        .Instruction   (Instruction),
        .PCnext        (PCnext),
        .readd1        (readd1),
        .readd2        (readd2),
        .ALUSrc        (ALUSrc),
        .MemtoReg      (MemtoReg),
        .MemWrite      (MemWrite),
        .MemRead       (MemRead),
        .RegWrite      (RegWrite),
        .ALUop         (ALUop),
        .PCJout        (PCJout),
        .SignExtendOut (SignExtendOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        bit         is_rd;
        logic [7:0] rd1;
        logic [7:0] rd2;
        logic [1:0] aluop;
        logic       alusrc;
        logic       m2r;
        logic       mw;
        logic       mr;
        logic       rw;
        logic [7:0] seo;
        logic [5:0] pc;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic chk(input string nm, input string fld, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s.%s: got 0x%02h expected 0x%02h", nm, fld, act, exp);
    endtask

    // Monitor: outputs are combinational, so compare mid-cycle against queued expectations.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            if (e.is_rd) begin
                chk(e.name, "readd1", readd1, e.rd1);
                chk(e.name, "readd2", readd2, e.rd2);
            end else begin
                chk(e.name, "ALUop",    8'(ALUop),    8'(e.aluop));
                chk(e.name, "ALUSrc",   8'(ALUSrc),   8'(e.alusrc));
                chk(e.name, "MemtoReg", 8'(MemtoReg), 8'(e.m2r));
                chk(e.name, "MemWrite", 8'(MemWrite), 8'(e.mw));
                chk(e.name, "MemRead",  8'(MemRead),  8'(e.mr));
                chk(e.name, "RegWrite", 8'(RegWrite), 8'(e.rw));
                chk(e.name, "SignExt",  SignExtendOut, e.seo);
                chk(e.name, "PCJout",   8'(PCJout),   8'(e.pc));
            end
        end
    end

    task automatic drive(input logic [31:0] ins, input logic [5:0] pcn, input logic z, input logic [7:0] wb);
        Instruction = ins;
        PCnext      = pcn;
        Zero        = z;
        WriteBack   = wb;
    endtask

    task automatic exp_rd(input string nm, input logic [7:0] r1, input logic [7:0] r2);
        exp_t e;
        e = '{name: nm, is_rd: 1'b1, rd1: r1, rd2: r2, aluop: 2'b00, alusrc: 1'b0, m2r: 1'b0,
              mw: 1'b0, mr: 1'b0, rw: 1'b0, seo: 8'h00, pc: 6'd0};
        q.push_back(e);
    endtask

    task automatic exp_ctl(input string nm, input logic [1:0] aop, input logic src, input logic m2r,
                           input logic mw, input logic mr, input logic rw, input logic [7:0] seo,
                           input logic [5:0] pc);
        exp_t e;
        e = '{name: nm, is_rd: 1'b0, rd1: 8'h00, rd2: 8'h00, aluop: aop, alusrc: src, m2r: m2r,
              mw: mw, mr: mr, rw: rw, seo: seo, pc: pc};
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] NOP = 32'hFC00_0000;

    initial begin
        // Reset held: addi r3 must not write across reset edges.
        rst = 1'b0;
        drive(32'h2003_0055, 6'd0, 1'b0, 8'h55);
        repeat (2) tick();
        exp_rd("rst_blocks_write", 8'h00, 8'h00);
        drive(NOP, 6'd0, 1'b0, 8'h00);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 32; i++) begin
            drive({6'h3F, 5'(i), 5'(31 - i), 16'h0000}, 6'd0, 1'b0, 8'h00);
            exp_rd($sformatf("rst_clear_r%0d", i), 8'h00, 8'h00);
            tick();
        end

        drive(32'h1060_0009, 6'd16, 1'b1, 8'h00);
        exp_ctl("beq_taken", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h09, 6'd25);
        tick();
        drive(32'h1060_0009, 6'd16, 1'b0, 8'h00);
        exp_ctl("beq_not_taken", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h09, 6'd16);
        tick();
        drive(32'h1060_000A, 6'd60, 1'b1, 8'h00);
        exp_ctl("beq_wrap", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0A, 6'd6);
        tick();
        drive(32'h1060_00FF, 6'd5, 1'b1, 8'h00);
        exp_ctl("beq_neg", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 6'd4);
        tick();
        drive(32'h0800_0005, 6'd3, 1'b1, 8'h00);
        exp_ctl("jump", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 6'd5);
        tick();

        // addi r5 <- 0x2A; no same-cycle bypass before the edge.
        drive(32'h2005_0007, 6'd9, 1'b0, 8'h2A);
        exp_ctl("addi_ctl", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h07, 6'd9);
        exp_rd("addi_no_bypass", 8'h00, 8'h00);
        tick();
        drive(32'h00A0_0000, 6'd10, 1'b0, 8'hEE);
        exp_rd("addi_readback", 8'h2A, 8'h00);
        exp_ctl("rtype_ctl", 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 6'd10);
        tick();

        // R-type rs=5 rt=4 rd=6 writes rd, not rt.
        drive(32'h00A4_3000, 6'd0, 1'b0, 8'h77);
        tick();
        drive(32'h00C5_0000, 6'd0, 1'b0, 8'h00);
        exp_rd("rtype_rd_write", 8'h77, 8'h2A);
        tick();
        drive(32'h0086_0000, 6'd0, 1'b0, 8'h00);
        exp_rd("rtype_rt_untouched", 8'h00, 8'h77);
        tick();

        drive(32'h0000_0000, 6'd0, 1'b0, 8'hFF);
        tick();
        drive(32'h0000_0000, 6'd0, 1'b0, 8'h00);
        exp_rd("write_r0_ignored", 8'h00, 8'h00);
        tick();

        drive(32'h8C00_0000, 6'd2, 1'b0, 8'h00);
        exp_ctl("lw_ctl", 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 6'd2);
        tick();
        drive(32'hAC00_0000, 6'd2, 1'b0, 8'h00);
        exp_ctl("sw_ctl", 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 6'd2);
        tick();
        drive(32'hFC00_1234, 6'd7, 1'b1, 8'h00);
        exp_ctl("nop_ctl", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h34, 6'd7);
        tick();

        // addi r7 <- 0x11, then async clear mid-cycle; write attempted under reset is dropped.
        drive(32'h2007_0000, 6'd0, 1'b0, 8'h11);
        tick();
        drive(32'h00E5_0000, 6'd0, 1'b0, 8'h00);
        exp_rd("r7_written", 8'h11, 8'h2A);
        tick();
        rst = 1'b0;
        drive(32'h20E7_0000, 6'd0, 1'b0, 8'h99);
        exp_rd("async_clear", 8'h00, 8'h00);
        tick();
        drive(32'h00E5_0000, 6'd0, 1'b0, 8'h00);
        rst = 1'b1;
        exp_rd("reset_write_dropped", 8'h00, 8'h00);
        tick();

        for (int k = 0; k < 10 && q.size() > 0; k++) tick();
        if (q.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
